// File: rtl/instruction_mem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader: default widths,
// memory capacity and the loader state encoding.
package instruction_mem_loader_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_SIZE   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    // The byte link is only open while a header, data or check byte is expected.
    function automatic logic state_accepts_bytes(input loader_state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/instruction_mem_loader_byte_word_packer.sv
// byte_word_packer: collects little-endian bytes into 32-bit words.
// The fully assembled word is also exposed combinationally during the 4th
// byte so the loader can decode the length header without an extra cycle.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        emit,
    output logic [1:0]  byte_cnt,
    output logic [31:0] assembled,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    assign byte_cnt  = cnt_q;
    assign assembled = {byte_in, shift_q};

    // Shift bytes in from the top so byte 0 ends up in the lowest lane; latch
    // the word and pulse word_valid when the 4th byte arrives and emit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (byte_valid) begin
                shift_q <= {byte_in, shift_q[23:8]};
                cnt_q   <= cnt_q + 2'd1;
                if ((cnt_q == 2'd3) && emit) begin
                    word_out   <= assembled;
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instruction_mem_loader.sv
// instruction_mem_loader: boot-time writer for the instruction store.
// Stream format: 4-byte little-endian word count N, then 4*N data bytes.
// Optional feature macro LOADER_CHECKSUM_EN adds a trailing modulo-256 sum
// byte over the data bytes; a mismatch sends the loader to the error state.
module instruction_mem_loader
    import instruction_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH_32        = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH_32        = DEF_DATA_WIDTH,
    parameter int INSTRUCTION_MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDR_WIDTH_32-1:0] wr_addr,
    output logic [DATA_WIDTH_32-1:0] wr_data,
    output logic                     core_hold,
    output logic                     done,
    output logic                     error
);

    localparam int WC = $clog2(INSTRUCTION_MEM_SIZE) + 1;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = ST_CHK;
`else
    localparam loader_state_t AFTER_DATA = ST_DONE;
`endif

    loader_state_t          state_q, state_d;
    logic [WC-1:0]          word_cnt_q;
    logic [WC-1:0]          len_q;
    logic [ADDR_WIDTH_32-1:0] wr_addr_q;

    logic        accept;
    logic        word_last_byte;
    logic        load_start;
    logic [1:0]  byte_cnt;
    logic [31:0] assembled;
    logic [31:0] pk_word;
    logic        pk_valid;

    assign in_ready       = state_accepts_bytes(state_q);
    assign accept         = in_valid && in_ready;
    assign word_last_byte = accept && (byte_cnt == 2'd3);
    assign load_start     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .byte_in    (in_data),
        .byte_valid (accept),
        .emit       (state_q == ST_DATA),
        .byte_cnt   (byte_cnt),
        .assembled  (assembled),
        .word_out   (pk_word),
        .word_valid (pk_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    // Running modulo-256 sum of data bytes only; restarts with every load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (load_start) begin
            sum_q <= '0;
        end else if ((state_q == ST_DATA) && accept) begin
            sum_q <= sum_q + in_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; the header is judged on the cycle its 4th byte arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (word_last_byte) begin
                    if (assembled == 32'd0) begin
                        state_d = AFTER_DATA;
                    end else if (assembled > 32'(INSTRUCTION_MEM_SIZE)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_last_byte && ((word_cnt_q + WC'(1)) == len_q)) begin
                    state_d = AFTER_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word count, length and write address; the address is taken from the
    // word index at the 4th byte so it lines up with the packer's write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            len_q      <= '0;
            wr_addr_q  <= '0;
        end else if (load_start) begin
            word_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            if ((state_q == ST_LEN) && word_last_byte) begin
                len_q <= assembled[WC-1:0];
            end
            if ((state_q == ST_DATA) && word_last_byte) begin
                wr_addr_q  <= ADDR_WIDTH_32'(word_cnt_q) << 2;
                word_cnt_q <= word_cnt_q + WC'(1);
            end
        end
    end

    assign wr_en     = pk_valid;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = pk_word;
    assign core_hold = (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Self-checking bench for instruction_mem_loader. Honors LOADER_CHECKSUM_EN
// so the same file drives both builds of the loader.
module tb_instruction_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_wr_t;

    typedef struct {
        logic [31:0] len_field;
        logic [31:0] seed;
        int          gap;
        logic [7:0]  chk_delta;
        logic        exp_done;
        logic        exp_error;
    } vec_t;

    exp_wr_t    exp_q[$];
    exp_wr_t    mon_e;
    vec_t       tests[8];
    int         n_compared = 0;
    int         n_mismatched = 0;
    logic [7:0] tb_sum;

    instruction_mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wr_addr", wr_addr, mon_e.addr);
                checkOutput("wr_data", wr_data, mon_e.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish within 2 ms");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL handshake_timeout: got in_ready=0 for 100 cycles, expected 1");
        end
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input logic [31:0] addr, input int gap);
        exp_wr_t e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                e.addr = addr;
                e.data = w;
                exp_q.push_back(e);
            end
            tb_sum = tb_sum + w[8*k +: 8];
            sendByte(w[8*k +: 8], gap);
        end
    endtask

    task automatic sendHeader(input logic [31:0] n);
        for (int k = 0; k < 4; k++) begin
            sendByte(n[8*k +: 8], 0);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] w;
        bit          accepted;
        exp_wr_t     e;
        accepted = (v.len_field <= 32'd1024);
        tb_sum = 8'h00;
        pulseStart();
        sendHeader(v.len_field);
        if (accepted) begin
            for (int i = 0; i < int'(v.len_field); i++) begin
                w = v.seed ^ (32'(i) * 32'h9E37_79B9);
                for (int k = 0; k < 4; k++) begin
                    if (k == 3) begin
                        e.addr = 32'(i) << 2;
                        e.data = w;
                        exp_q.push_back(e);
                    end
                    tb_sum = tb_sum + w[8*k +: 8];
                    sendByte(w[8*k +: 8], v.gap);
                    if (v.gap > 0 && i == 0 && k == 0) begin
                        pulseStart();
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            sendByte(tb_sum + v.chk_delta, 0);
`endif
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("done", 32'(done), 32'(v.exp_done));
        checkOutput("error", 32'(error), 32'(v.exp_error));
        checkOutput("core_hold", 32'(core_hold), 32'(!v.exp_done));
        checkOutput("in_ready_after", 32'(in_ready), 32'd0);
        checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // len, seed, gap, chk_delta, exp_done, exp_error
        tests[0] = '{32'd1,          32'h0000_0013, 0, 8'd0, 1'b1, 1'b0};
        tests[1] = '{32'd4,          32'hDEAD_BEEF, 1, 8'd0, 1'b1, 1'b0};
        tests[2] = '{32'd0,          32'h0000_0000, 0, 8'd0, 1'b1, 1'b0};
        tests[3] = '{32'd1025,       32'h0000_0000, 0, 8'd0, 1'b0, 1'b1};
`ifdef LOADER_CHECKSUM_EN
        tests[4] = '{32'd1,          32'h0000_0013, 0, 8'd1, 1'b0, 1'b1};
`else
        tests[4] = '{32'd1,          32'h0000_0013, 0, 8'd1, 1'b1, 1'b0};
`endif
        tests[5] = '{32'd1024,       32'h1234_5678, 0, 8'd0, 1'b1, 1'b0};
        tests[6] = '{32'h0001_0000,  32'h0000_0000, 0, 8'd0, 1'b0, 1'b1};
        tests[7] = '{32'd3,          32'hCAFE_0000, 2, 8'd0, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_core_hold", 32'(core_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", wr_addr, 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference stream: final write and DONE entry share a cycle.
        tb_sum = 8'h00;
        pulseStart();
        checkOutput("len_in_ready", 32'(in_ready), 32'd1);
        sendHeader(32'd2);
        sendWord(32'h0000_0013, 32'h0, 0);
        sendWord(32'h0010_0093, 32'h4, 0);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("chk_in_ready", 32'(in_ready), 32'd1);
        checkOutput("chk_sum_model", 32'(tb_sum), 32'hB6);
        sendByte(8'hB6, 0);
`else
        checkOutput("last_wr_en", 32'(wr_en), 32'd1);
        checkOutput("last_done", 32'(done), 32'd1);
`endif
        @(posedge clk); #1;
        checkOutput("ref_done", 32'(done), 32'd1);
        checkOutput("ref_core_hold", 32'(core_hold), 32'd0);

        // Table-driven loads, including rejects and reloads from DONE/ERR.
        for (int t = 0; t < 8; t++) begin
            applyStimulus(tests[t]);
        end

        // Reset in the middle of DATA aborts the load.
        tb_sum = 8'h00;
        pulseStart();
        sendHeader(32'd3);
        sendWord(32'hA5A5_0001, 32'h0, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
        checkOutput("abort_core_hold", 32'(core_hold), 32'd1);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort_wr_addr", wr_addr, 32'd0);
        checkOutput("abort_wr_data", wr_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        tb_sum = 8'h00;
        pulseStart();
        sendHeader(32'd2);
        sendWord(32'h0000_0111, 32'h0, 0);
        sendWord(32'h0000_0222, 32'h4, 0);
`ifdef LOADER_CHECKSUM_EN
        sendByte(tb_sum, 0);
`endif
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("reload_done", 32'(done), 32'd1);
        checkOutput("reload_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
